// File: rtl/dial_pkg.sv
// Shared definitions for the rotary dial quadrature decoder:
// edge codes, controller states and the Gray-code step decoder.
package dial_pkg;

   typedef logic [1:0] edge_t;

   localparam edge_t EDGE_NONE = 2'd0;
   localparam edge_t EDGE_CW   = 2'd1;
   localparam edge_t EDGE_CCW  = 2'd2;
   localparam edge_t EDGE_ERR  = 2'd3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Classify the move from prev_ab to cur_ab ({a,b}).
   // CW order is 00 -> 01 -> 11 -> 10 -> 00; both bits changing is illegal.
   function automatic edge_t decode_edge(input logic [1:0] prev_ab,
                                         input logic [1:0] cur_ab);
      edge_t result;
      result = EDGE_NONE;
      case ({prev_ab, cur_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: result = EDGE_CW;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: result = EDGE_CCW;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: result = EDGE_ERR;
         default:                                result = EDGE_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dial_debounce.sv
// One dial channel: two-flop synchroniser followed by a stability counter.
// While learn is high the debounced level tracks the synchronised input
// directly, so the controller can adopt the dial's resting level.
module dial_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic learn,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             sync1_r;
   logic             sync2_r;
   logic [CNT_W-1:0] cnt_r;

   // Two-flop synchroniser for the asynchronous dial phase
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
      end
   end

   // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r <= {CNT_W{1'b0}};
         level <= 1'b0;
      end else if (learn) begin
         cnt_r <= {CNT_W{1'b0}};
         level <= sync2_r;
      end else if (sync2_r == level) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_r <= {CNT_W{1'b0}};
         level <= sync2_r;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dial_quadrature_decoder.sv
// Front-panel rotary dial decoder: synchronises and debounces both phases,
// decodes Gray-code edges and accumulates them into detent steps that move
// a wrapping position count feeding the dial PIO input port.
module dial_quadrature_decoder
   import dial_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int EDGES_PER_COUNT = 4,
   parameter int COUNT_WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enc_a,
   input  logic                   enc_b,
   input  logic                   count_clear,
   output logic [COUNT_WIDTH-1:0] position,
   output logic                   step_pulse,
   output logic                   step_dir,
   output logic                   quad_error
);

   // INIT spans the synchroniser fill plus one full debounce window
   localparam int                 INIT_W    = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
   localparam logic signed [3:0]  EPC       = 4'(EDGES_PER_COUNT);

   state_t             state_r;
   logic [INIT_W-1:0]  init_cnt_r;
   logic [1:0]         prev_ab_r;
   logic signed [3:0]  acc_r;

   logic               a_level_s;
   logic               b_level_s;
   logic               learn_s;
   logic [1:0]         cur_ab_s;
   edge_t              edge_s;
   logic signed [3:0]  acc_sum_s;

   assign learn_s  = (state_r == INIT);
   assign cur_ab_s = {a_level_s, b_level_s};
   assign edge_s   = decode_edge(prev_ab_r, cur_ab_s);

   dial_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_a (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (enc_a),
      .learn   (learn_s),
      .level   (a_level_s)
   );

   dial_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_b (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (enc_b),
      .learn   (learn_s),
      .level   (b_level_s)
   );

   // Accumulator value after absorbing this cycle's edge (unchanged otherwise)
   always_comb begin
      acc_sum_s = acc_r;
      case (edge_s)
         EDGE_CW:  acc_sum_s = acc_r + 4'sd1;
         EDGE_CCW: acc_sum_s = acc_r - 4'sd1;
         default:  acc_sum_s = acc_r;
      endcase
   end

   // Controller: learn the resting level in INIT, then count detents in RUN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= INIT;
         init_cnt_r <= {INIT_W{1'b0}};
         prev_ab_r  <= 2'b00;
         acc_r      <= 4'sd0;
         position   <= {COUNT_WIDTH{1'b0}};
         step_pulse <= 1'b0;
         step_dir   <= 1'b0;
         quad_error <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         quad_error <= 1'b0;
         case (state_r)
            INIT: begin
               prev_ab_r <= cur_ab_s;
               if (init_cnt_r == INIT_LAST) begin
                  state_r <= RUN;
               end else begin
                  init_cnt_r <= init_cnt_r + INIT_W'(1);
               end
               if (count_clear) begin
                  position <= {COUNT_WIDTH{1'b0}};
                  acc_r    <= 4'sd0;
               end
            end
            RUN: begin
               prev_ab_r  <= cur_ab_s;
               quad_error <= (edge_s == EDGE_ERR);
               // A clear drops any step completing in the same cycle
               if (count_clear) begin
                  position <= {COUNT_WIDTH{1'b0}};
                  acc_r    <= 4'sd0;
               end else if (acc_sum_s == EPC) begin
                  position   <= position + COUNT_WIDTH'(1);
                  step_pulse <= 1'b1;
                  step_dir   <= 1'b1;
                  acc_r      <= 4'sd0;
               end else if (acc_sum_s == -EPC) begin
                  position   <= position - COUNT_WIDTH'(1);
                  step_pulse <= 1'b1;
                  step_dir   <= 1'b0;
                  acc_r      <= 4'sd0;
               end else begin
                  acc_r <= acc_sum_s;
               end
            end
            default: begin
               state_r    <= INIT;
               init_cnt_r <= {INIT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dial_quadrature_decoder.sv
// Scoreboard bench for dial_quadrature_decoder: stimulus pushes expected
// steps / quadrature errors with their due cycle, a monitor pops and compares.
module tb_dial_quadrature_decoder;

   localparam int DEB = 4;
   localparam int EPC = 4;
   localparam int CW  = 8;
   localparam int LAT = DEB + 3;

   logic          clk;
   logic          reset_n;
   logic          enc_a;
   logic          enc_b;
   logic          count_clear;
   logic [CW-1:0] position;
   logic          step_pulse;
   logic          step_dir;
   logic          quad_error;

   typedef struct {
      int pos;
      int dir;
      int cyc;
   } step_exp_t;

   step_exp_t step_q[$];
   int        qerr_q[$];
   step_exp_t mon_e;
   int        mon_c;
   int        cyc    = 0;
   int        errors = 0;
   int        checks = 0;

   dial_quadrature_decoder #(
      .DEBOUNCE_CYCLES (DEB),
      .EDGES_PER_COUNT (EPC),
      .COUNT_WIDTH     (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enc_a       (enc_a),
      .enc_b       (enc_b),
      .count_clear (count_clear),
      .position    (position),
      .step_pulse  (step_pulse),
      .step_dir    (step_dir),
      .quad_error  (quad_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest expected entry
   always @(posedge clk) begin
      #1;
      if (step_pulse === 1'b1) begin
         if (step_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_step: got pulse at cycle %0d position %0d, required none", cyc, position);
         end else begin
            mon_e = step_q.pop_front();
            check("step_position", int'(position), mon_e.pos);
            check("step_dir", int'(step_dir), mon_e.dir);
            check("step_cycle", cyc, mon_e.cyc);
         end
      end
      if (quad_error === 1'b1) begin
         if (qerr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_quad_error: got strobe at cycle %0d, required none", cyc);
         end else begin
            mon_c = qerr_q.pop_front();
            check("quad_error_cycle", cyc, mon_c);
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] ab, input bit exp_step, input int pos, input int dir);
      step_exp_t e;
      enc_a = ab[1];
      enc_b = ab[0];
      if (exp_step) begin
         e.pos = pos;
         e.dir = dir;
         e.cyc = cyc + LAT;
         step_q.push_back(e);
      end
   endtask

   task automatic move(input logic [1:0] ab, input bit exp_step, input int pos, input int dir);
      drive(ab, exp_step, pos, dir);
      hold(10);
   endtask

   initial begin
      reset_n     = 1'b0;
      enc_a       = 1'b1;
      enc_b       = 1'b1;
      count_clear = 1'b0;
      @(negedge clk);

      // 1: dial resting at 11 through reset and INIT
      hold(3);
      reset_n = 1'b1;
      hold(20);
      check("init_position", int'(position), 0);
      check("init_step_pulse", int'(step_pulse), 0);
      check("init_quad_error", int'(quad_error), 0);

      // Re-learn with the dial resting at 00
      enc_a   = 1'b0;
      enc_b   = 1'b0;
      reset_n = 1'b0;
      hold(3);
      reset_n = 1'b1;
      hold(20);
      check("relearn_position", int'(position), 0);

      // 2: one CW detent
      move(2'b01, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b1, 1, 1);
      check("cw_position", int'(position), 1);

      // 3: clear, then two CCW detents wrapping below zero
      count_clear = 1'b1;
      hold(1);
      count_clear = 1'b0;
      hold(2);
      check("clear_position", int'(position), 0);
      move(2'b10, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      move(2'b01, 1'b0, 0, 0);
      move(2'b00, 1'b1, 255, 0);
      move(2'b10, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      move(2'b01, 1'b0, 0, 0);
      move(2'b00, 1'b1, 254, 0);
      check("ccw_position", int'(position), 254);

      // 4: short glitch, then a reversal mid-detent
      enc_a = 1'b1;
      hold(3);
      enc_a = 1'b0;
      hold(10);
      check("glitch_position", int'(position), 254);
      move(2'b01, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      move(2'b01, 1'b0, 0, 0);
      move(2'b00, 1'b0, 0, 0);
      check("reversal_position", int'(position), 254);
      move(2'b01, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b1, 255, 1);

      // 5: illegal 00 -> 11 jump, then a CW detent from 11 wrapping to 0
      drive(2'b11, 1'b0, 0, 0);
      qerr_q.push_back(cyc + LAT);
      hold(10);
      check("qerr_position", int'(position), 255);
      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b0, 0, 0);
      move(2'b01, 1'b0, 0, 0);
      move(2'b11, 1'b1, 0, 1);

      // 6: walk up to 5, clear in the completing cycle, then reset mid-detent
      for (int i = 1; i <= 5; i++) begin
         move(2'b10, 1'b0, 0, 0);
         move(2'b00, 1'b0, 0, 0);
         move(2'b01, 1'b0, 0, 0);
         move(2'b11, 1'b1, i, 1);
      end
      check("walk_position", int'(position), 5);
      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b0, 0, 0);
      move(2'b01, 1'b0, 0, 0);
      drive(2'b11, 1'b0, 0, 0);
      hold(LAT - 1);
      count_clear = 1'b1;
      hold(1);
      count_clear = 1'b0;
      hold(3);
      check("clear_step_position", int'(position), 0);
      check("clear_step_dir_hold", int'(step_dir), 1);

      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b0, 0, 0);
      reset_n = 1'b0;
      hold(3);
      reset_n = 1'b1;
      hold(15);
      check("midreset_position", int'(position), 0);
      check("midreset_step_dir", int'(step_dir), 0);
      move(2'b01, 1'b0, 0, 0);
      move(2'b11, 1'b0, 0, 0);
      check("midreset_half_position", int'(position), 0);
      move(2'b10, 1'b0, 0, 0);
      move(2'b00, 1'b1, 1, 1);
      hold(20);

      check("pending_steps", step_q.size(), 0);
      check("pending_quad_errors", qerr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
